neuron_layer_sched: RTL and testbench
=====================================

Name: neuron_layer_sched

Overview:
Sequential scheduler that time-multiplexes one signed multiply-accumulate datapath across M output neurons of a fully connected layer, computing y[m] = ReLU(sum_i x[i]*W[m][i] + B[m]). Fetches weights and biases from external combinational-read memories, performs one MAC per cycle, and streams results out on a valid/ready handshake. Replaces M parallel combinational neurons when area matters.

Parameters:
N, 4, inputs per neuron (N >= 1)
M, 3, neurons in the layer (M >= 1)
WIDTH, 8, signed width of x, weight and bias words
ACCW, 2*WIDTH+2, signed accumulator and result width
WA, clog2(M*N) (min 1), weight address width
MA, clog2(M) (min 1), neuron index width

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset; one clock, synchronous, active-low
start  in  1  begin a layer pass; sampled only in IDLE
abort  in  1  synchronous cancel; return to IDLE, no done
x_in  in  N*WIDTH  signed inputs, x[i] = x_in[i*WIDTH +: WIDTH]; latched on accepted start
w_addr  out  WA  weight address = m*N + i
w_data  in  WIDTH  signed weight at w_addr, same cycle
b_addr  out  MA  bias address = current neuron m
b_data  in  WIDTH  signed bias at b_addr, same cycle
y_valid  out  1  result available
y_ready  in  1  consumer accepts result
y_idx  out  MA  neuron index of y_data
y_data  out  ACCW  ReLU result, zero-extended non-negative
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after last result accepted

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; y_valid, y_idx, y_data, busy, done, w_addr, b_addr, accumulator, counters all 0; latched x cleared. Applies mid-pass; the partial pass is discarded.
- States: IDLE, BIAS, MAC, OUT.
- IDLE: start=1 -> latch x_in, m=0, go BIAS. Otherwise stay. done=0 except the pulse cycle below.
- BIAS (1 cycle): b_addr=m; acc <= sign-extended b_data; i=0; go MAC.
- MAC (N cycles): w_addr=m*N+i; acc <= acc + x[i]*w_data (full-precision signed product, sign-extended to ACCW); i increments; after i=N-1 go OUT.
- OUT: y_valid=1, y_idx=m, y_data = acc if acc >= 0 else 0; held stable until y_valid&&y_ready. On handshake: m<M-1 -> m++, go BIAS; m=M-1 -> go IDLE with done=1 for that single next cycle.
- Per-neuron latency with y_ready=1: start at edge k -> BIAS cycle k+1, MAC k+2..k+N+1, y_valid cycle k+N+2. Full pass: M*(N+2) cycles plus done cycle.
- Backpressure: y_ready=0 in OUT stalls indefinitely, no state change, output stable.
- start while busy: ignored. start in the done-pulse cycle: accepted (state is IDLE).
- abort=1 in any non-IDLE state: next state IDLE, y_valid=0, no done pulse. abort in IDLE: no effect. abort and start together in IDLE: abort wins, start ignored. rst_n has priority over abort.
- x_in changes after start have no effect until next accepted start.
- Arithmetic: two's complement, accumulator wraps modulo 2^ACCW (no saturation); defaults cannot overflow (max |sum| = 4*16384+128 < 2^17).
- w_addr, b_addr = 0 when not in MAC/BIAS respectively.

Test Plan:
- Reset mid-MAC: rst_n low 1 cycle during neuron 1 MAC -> busy=0, y_valid=0, done never pulses; subsequent start runs clean pass from m=0.
- Basic pass: x=(1,2,3,4), W[m]=all 1, B=(5,0,-20), y_ready=1 -> y_valid at cycles 6,12,18 after start edge, y=(15,10,0), y_idx=0,1,2, done pulse cycle 19.
- Mixed signs: x=(5,-3,2,1), W[0]=(2,2,2,2), B[0]=3 -> y=13; W[1]=(2,-2,2,-2), B[1]=-3 with x=(-5,3,-2,1) -> 0 (ReLU of -25).
- Extremes: x=all -128, W=all -128, B=127 -> y=65663; W=all 127 -> ReLU(-65024+127) = 0; no wrap.
- Backpressure: y_ready low 5 cycles during neuron 0 OUT -> y_valid, y_data, y_idx stable, w_addr=0, pass completes with same values; start pulses while busy ignored.
- Abort: abort during neuron 2 MAC -> IDLE next cycle, no done; start with abort same cycle in IDLE -> stays IDLE; start in done-pulse cycle -> busy next cycle.

Source files
------------

// File: rtl/neuron_layer_sched_if.sv
// Result stream of the layer scheduler: valid/ready handshake
// carrying neuron index and ReLU output. master = producer.
interface neuron_layer_sched_if #(
  parameter int MA   = 2,
  parameter int ACCW = 18
);
  logic            y_valid;
  logic            y_ready;
  logic [MA-1:0]   y_idx;
  logic [ACCW-1:0] y_data;

  modport master (
    output y_valid,
    output y_idx,
    output y_data,
    input  y_ready
  );

  modport slave (
    input  y_valid,
    input  y_idx,
    input  y_data,
    output y_ready
  );
endinterface

// File: rtl/neuron_layer_sched.sv
// One shared signed MAC computes y[m]=ReLU(sum x[i]*W[m][i]+B[m])
// for M neurons. Ports: clk, rst_n (sync, active-low), start,
// abort, x_in (latched on start), w_addr/w_data and b_addr/b_data
// (combinational-read memories), busy, done, y (result stream).
module neuron_layer_sched #(
  parameter int N     = 4,
  parameter int M     = 3,
  parameter int WIDTH = 8,
  parameter int ACCW  = 2*WIDTH+2,
  parameter int WA    = (M*N > 1) ? $clog2(M*N) : 1,
  parameter int MA    = (M > 1) ? $clog2(M) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N*WIDTH-1:0]   x_in,
  output logic [WA-1:0]        w_addr,
  input  logic [WIDTH-1:0]     w_data,
  output logic [MA-1:0]        b_addr,
  input  logic [WIDTH-1:0]     b_data,
  output logic                 busy,
  output logic                 done,
  neuron_layer_sched_if.master y
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BIAS,
    MAC,
    OUT
  } state_t;

  state_t state;
  state_t nxt;

  logic signed [WIDTH-1:0]   x_r [N];
  logic [MA-1:0]             m;
  logic [IW-1:0]             i;
  logic [WA-1:0]             wp;
  logic signed [ACCW-1:0]    acc;

  logic                      hs;
  logic                      last_i;
  logic                      last_m;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACCW-1:0]    prod_x;
  logic signed [ACCW-1:0]    bias_x;

  assign hs     = (state == OUT) && y.y_ready;
  assign last_i = (i == IW'(N-1));
  assign last_m = (m == MA'(M-1));
  assign prod   = x_r[i] * $signed(w_data);
  assign prod_x = {{(ACCW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign bias_x = {{(ACCW-WIDTH){b_data[WIDTH-1]}}, b_data};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start && !abort) nxt = BIAS;
      BIAS: nxt = abort ? IDLE : MAC;
      MAC: begin
        if (abort)       nxt = IDLE;
        else if (last_i) nxt = OUT;
      end
      OUT: begin
        if (abort)   nxt = IDLE;
        else if (hs) nxt = last_m ? IDLE : BIAS;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    w_addr    = '0;
    b_addr    = '0;
    y.y_valid = 1'b0;
    y.y_idx   = '0;
    y.y_data  = '0;
    unique case (state)
      BIAS: b_addr = m;
      MAC:  w_addr = wp;
      OUT: begin
        y.y_valid = 1'b1;
        y.y_idx   = m;
        if (!acc[ACCW-1]) y.y_data = $unsigned(acc);
      end
      default: ;
    endcase
  end

  // wp walks m*N+i linearly across the pass, so no multiplier
  // is needed for the weight address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) x_r[k] <= '0;
      m    <= '0;
      i    <= '0;
      wp   <= '0;
      acc  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            for (int k = 0; k < N; k++)
              x_r[k] <= x_in[k*WIDTH +: WIDTH];
            m  <= '0;
            wp <= '0;
          end
        end
        BIAS: begin
          acc <= bias_x;
          i   <= '0;
        end
        MAC: begin
          acc <= acc + prod_x;
          i   <= i + 1'b1;
          wp  <= wp + 1'b1;
        end
        OUT: begin
          if (hs && !abort) begin
            if (last_m) done <= 1'b1;
            else        m    <= m + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Directed bench for neuron_layer_sched: models weight/bias
// memories and checks every result against hand-computed values.
module tb_neuron_layer_sched;
  localparam int N     = 4;
  localparam int M     = 3;
  localparam int WIDTH = 8;
  localparam int ACCW  = 18;
  localparam int WA    = 4;
  localparam int MA    = 2;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [N*WIDTH-1:0] x_in  = '0;
  logic [WA-1:0]      w_addr;
  logic [WIDTH-1:0]   w_data;
  logic [MA-1:0]      b_addr;
  logic [WIDTH-1:0]   b_data;
  logic               busy;
  logic               done;

  logic [WIDTH-1:0] w_mem [M*N];
  logic [WIDTH-1:0] b_mem [M];

  int vectors     = 0;
  int miscompares = 0;

  neuron_layer_sched_if #(.MA(MA), .ACCW(ACCW)) yif ();

  assign w_data = w_mem[w_addr];
  assign b_data = b_mem[b_addr];

  always #5 clk = ~clk;

  neuron_layer_sched #(
    .N(N), .M(M), .WIDTH(WIDTH), .ACCW(ACCW), .WA(WA), .MA(MA)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .x_in   (x_in),
    .w_addr (w_addr),
    .w_data (w_data),
    .b_addr (b_addr),
    .b_data (b_data),
    .busy   (busy),
    .done   (done),
    .y      (yif)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_x(input int a, input int b,
                       input int c, input int d);
    x_in = {8'(d), 8'(c), 8'(b), 8'(a)};
  endtask

  task automatic set_w(input int n, input int a, input int b,
                       input int c, input int d, input int bias);
    w_mem[n*N+0] = 8'(a);
    w_mem[n*N+1] = 8'(b);
    w_mem[n*N+2] = 8'(c);
    w_mem[n*N+3] = 8'(d);
    b_mem[n]     = 8'(bias);
  endtask

  task automatic start_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // lat counts cycles since the start or handshake edge
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!yif.y_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic collect(input string tag, input int idx,
                         input int data, input bit chk_lat);
    int lat;
    wait_valid(lat);
    chk({tag, "_valid"}, 64'(yif.y_valid), 1);
    if (chk_lat) chk({tag, "_lat"}, 64'(lat), 6);
    chk({tag, "_idx"}, 64'(yif.y_idx), 64'(idx));
    chk({tag, "_data"}, 64'(yif.y_data), 64'(data));
    tick();
  endtask

  task automatic no_done(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk(tag, 64'(seen), 0);
  endtask

  initial begin
    yif.y_ready = 1'b1;
    for (int k = 0; k < M; k++) set_w(k, 1, 1, 1, 1, 0);
    b_mem[0] = 8'd5;
    b_mem[1] = 8'd0;
    b_mem[2] = 8'(-20);
    set_x(1, 2, 3, 4);

    tick();
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_valid", 64'(yif.y_valid), 0);
    chk("rst_idx", 64'(yif.y_idx), 0);
    chk("rst_data", 64'(yif.y_data), 0);
    chk("rst_waddr", 64'(w_addr), 0);
    chk("rst_baddr", 64'(b_addr), 0);
    rst_n = 1'b1;
    tick();

    // reset during neuron 1 MAC
    start_pass();
    collect("mr0", 0, 15, 1'b1);
    chk("mr_baddr", 64'(b_addr), 1);
    tick();
    tick();
    chk("mr_waddr", 64'(w_addr), 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_busy", 64'(busy), 0);
    chk("mr_valid", 64'(yif.y_valid), 0);
    chk("mr_done", 64'(done), 0);
    chk("mr_waddr0", 64'(w_addr), 0);
    no_done("mr_nodone", 20);

    // basic pass
    start_pass();
    collect("b0", 0, 15, 1'b1);
    collect("b1", 1, 10, 1'b1);
    collect("b2", 2, 0, 1'b1);
    chk("b_done", 64'(done), 1);
    chk("b_busy", 64'(busy), 0);
    tick();
    chk("b_done_end", 64'(done), 0);

    // mixed signs
    set_w(0, 2, 2, 2, 2, 3);
    set_w(1, 2, -2, 2, -2, -3);
    set_w(2, 0, 0, 1, 0, 4);
    set_x(5, -3, 2, 1);
    start_pass();
    collect("ma0", 0, 13, 1'b1);
    collect("ma1", 1, 15, 1'b1);
    collect("ma2", 2, 6, 1'b1);
    chk("ma_done", 64'(done), 1);
    tick();
    set_x(-5, 3, -2, 1);
    start_pass();
    collect("mb0", 0, 0, 1'b1);
    collect("mb1", 1, 0, 1'b1);
    collect("mb2", 2, 2, 1'b1);
    chk("mb_done", 64'(done), 1);
    tick();

    // extremes
    set_w(0, -128, -128, -128, -128, 127);
    set_w(1, 127, 127, 127, 127, 127);
    set_w(2, -128, -128, -128, -128, -128);
    set_x(-128, -128, -128, -128);
    start_pass();
    collect("ex0", 0, 65663, 1'b1);
    collect("ex1", 1, 0, 1'b1);
    collect("ex2", 2, 65408, 1'b1);
    chk("ex_done", 64'(done), 1);
    tick();

    // backpressure on neuron 0, start and x_in noise while busy
    set_w(0, 2, 2, 2, 2, 3);
    set_w(1, 2, -2, 2, -2, -3);
    set_w(2, 0, 0, 1, 0, 4);
    set_x(5, -3, 2, 1);
    yif.y_ready = 1'b0;
    start_pass();
    collect_stall : begin
      int lat;
      wait_valid(lat);
      chk("bp_lat", 64'(lat), 6);
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(yif.y_valid), 1);
      chk("bp_idx", 64'(yif.y_idx), 0);
      chk("bp_data", 64'(yif.y_data), 13);
      chk("bp_waddr", 64'(w_addr), 0);
      chk("bp_busy", 64'(busy), 1);
      start = 1'b1;
      set_x(0, 0, 0, 0);
      tick();
    end
    start = 1'b0;
    yif.y_ready = 1'b1;
    collect("bp0", 0, 13, 1'b0);
    collect("bp1", 1, 15, 1'b1);
    collect("bp2", 2, 6, 1'b1);
    chk("bp_done", 64'(done), 1);
    tick();

    // abort during neuron 2 MAC
    set_x(5, -3, 2, 1);
    start_pass();
    collect("ab0", 0, 13, 1'b1);
    collect("ab1", 1, 15, 1'b1);
    tick();
    tick();
    chk("ab_waddr", 64'(w_addr), 9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", 64'(busy), 0);
    chk("ab_valid", 64'(yif.y_valid), 0);
    chk("ab_done", 64'(done), 0);
    chk("ab_waddr0", 64'(w_addr), 0);
    no_done("ab_nodone", 8);

    // abort and start together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 64'(busy), 0);
    tick();
    chk("sa_busy2", 64'(busy), 0);

    // start accepted in the done-pulse cycle
    start_pass();
    collect("dp0", 0, 13, 1'b1);
    collect("dp1", 1, 15, 1'b1);
    collect("dp2", 2, 6, 1'b1);
    chk("dp_done", 64'(done), 1);
    start_pass();
    chk("dp_busy", 64'(busy), 1);
    chk("dp_baddr", 64'(b_addr), 0);
    collect("dq0", 0, 13, 1'b1);
    collect("dq1", 1, 15, 1'b1);
    collect("dq2", 2, 6, 1'b1);
    chk("dq_done", 64'(done), 1);
    tick();
    chk("dq_idle", 64'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
